// File: rtl/cpu_seq_ctrl.sv
// -----------------------------------------------------------------------------
// cpu_seq_ctrl
//   Multi-cycle sequencer for the 4-bit-opcode CPU (add / iadd / st / ld).
//   Holds PC and IR and walks FETCH -> DECODE -> EXEC -> MEM -> WB. It drives
//   the register-file, ALU and data-memory strobes one state at a time, and runs
//   the req/ack handshakes to instruction and data memory.
//
//   Opcodes (ir[IW-1:IW-4]):
//     0 add   1 iadd   2 st   3 ld   15 halt   4..14 illegal
//
// Parameters
//   PC_W  program counter / instruction address width
//   IW    instruction width
//
// Ports
//   clk, rst_n      clock (rising edge), asynchronous active-low reset
//   start           begin execution from pc=0 (accepted only in IDLE/HALT)
//   imem_req/addr   instruction fetch request and address (= pc)
//   imem_ack, ins   fetch completion and instruction word
//   ir              latched instruction, feeds the datapath register fields
//   dmem_req/ack    data memory access handshake (st/ld)
//   wr_en           register file write strobe
//   m_wr_en         data memory write enable (st, on every dmem_req cycle)
//   select0         ALU B-mux, 1 = immediate (iadd)
//   select1         writeback mux, 1 = memory data (ld)
//   alu_op          ALU operation
//   busy            high in every state except IDLE/HALT
//   halted          high in HALT
//   illegal         1-cycle pulse when an undefined opcode is decoded
//   icnt            retired-instruction count
//
// Configuration
//   CPU_SEQ_ICNT_EN  when defined, icnt counts retired instructions (cleared on
//                    reset and on accepted start, wraps at 2^32). When
//                    undefined, icnt is tied to zero and no counter exists.
// -----------------------------------------------------------------------------
module cpu_seq_ctrl #(
    parameter int unsigned PC_W = 8,
    parameter int unsigned IW   = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    output logic            imem_req,
    output logic [PC_W-1:0] imem_addr,
    input  logic            imem_ack,
    input  logic [IW-1:0]   ins,
    output logic [IW-1:0]   ir,
    output logic            dmem_req,
    input  logic            dmem_ack,
    output logic            wr_en,
    output logic            m_wr_en,
    output logic            select0,
    output logic            select1,
    output logic [2:0]      alu_op,
    output logic            busy,
    output logic            halted,
    output logic            illegal,
    output logic [31:0]     icnt
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_MEM,
        S_WB,
        S_HALT
    } state_t;

    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_IADD = 4'd1;
    localparam logic [3:0] OP_ST   = 4'd2;
    localparam logic [3:0] OP_HALT = 4'd15;

    state_t          state;
    state_t          state_nx;
    logic [PC_W-1:0] pc;
    logic [PC_W-1:0] pc_nx;
    logic [PC_W-1:0] pc_inc;
    logic [IW-1:0]   ir_q;
    logic [IW-1:0]   ir_nx;
    logic [3:0]      opcode;
    logic            op_is_st;
    logic            op_is_iadd;

    assign opcode     = ir_q[IW-1 -: 4];
    assign op_is_st   = (opcode == OP_ST);
    assign op_is_iadd = (opcode == OP_IADD);
    // pc wraps silently at 2^PC_W
    assign pc_inc     = pc + PC_W'(1);

    assign imem_addr = pc;
    assign ir        = ir_q;
    assign busy      = (state != S_IDLE) && (state != S_HALT);
    assign halted    = (state == S_HALT);

    // -------------------------------------------------------------------------
    // State, PC and IR registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
            pc    <= '0;
            ir_q  <= '0;
        end else begin
            state <= state_nx;
            pc    <= pc_nx;
            ir_q  <= ir_nx;
        end
    end

    // -------------------------------------------------------------------------
    // Next-state and strobe decode
    // -------------------------------------------------------------------------
    always_comb begin
        state_nx = state;
        pc_nx    = pc;
        ir_nx    = ir_q;
        imem_req = 1'b0;
        dmem_req = 1'b0;
        wr_en    = 1'b0;
        m_wr_en  = 1'b0;
        select0  = 1'b0;
        select1  = 1'b0;
        alu_op   = 3'b000;
        illegal  = 1'b0;

        case (state)
            S_IDLE, S_HALT: begin
                if (start) begin
                    pc_nx    = '0;
                    state_nx = S_FETCH;
                end
            end

            S_FETCH: begin
                imem_req = 1'b1;
                if (imem_ack) begin
                    ir_nx    = ins;
                    state_nx = S_DECODE;
                end
            end

            S_DECODE: begin
                if (opcode == OP_HALT) begin
                    state_nx = S_HALT;
                end else if (opcode <= 4'd3) begin
                    state_nx = S_EXEC;
                end else begin
                    // Undefined opcode: flag it and skip to the next word.
                    illegal  = 1'b1;
                    pc_nx    = pc_inc;
                    state_nx = S_FETCH;
                end
            end

            S_EXEC: begin
                alu_op  = opcode[2:0];
                select0 = op_is_iadd;
                if ((opcode == OP_ADD) || op_is_iadd) begin
                    wr_en    = 1'b1;
                    pc_nx    = pc_inc;
                    state_nx = S_FETCH;
                end else begin
                    state_nx = S_MEM;
                end
            end

            S_MEM: begin
                // ALU controls stay as in EXEC so the address path is stable
                // for the whole handshake.
                alu_op   = opcode[2:0];
                select0  = op_is_iadd;
                dmem_req = 1'b1;
                m_wr_en  = op_is_st;
                if (dmem_ack) begin
                    if (op_is_st) begin
                        pc_nx    = pc_inc;
                        state_nx = S_FETCH;
                    end else begin
                        state_nx = S_WB;
                    end
                end
            end

            S_WB: begin
                wr_en    = 1'b1;
                select1  = 1'b1;
                alu_op   = 3'b011;
                pc_nx    = pc_inc;
                state_nx = S_FETCH;
            end

            default: begin
                state_nx = S_IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Retired-instruction counter
    // -------------------------------------------------------------------------
`ifdef CPU_SEQ_ICNT_EN
    logic        retire;
    logic        start_acc;
    logic [31:0] icnt_q;

    // Retire points: add/iadd in EXEC, st on its data ack, ld in WB.
    assign retire = ((state == S_EXEC) && (opcode[3:1] == 3'b000))
                 || ((state == S_MEM) && dmem_ack && op_is_st)
                 ||  (state == S_WB);
    assign start_acc = start && ((state == S_IDLE) || (state == S_HALT));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            icnt_q <= '0;
        end else if (start_acc) begin
            icnt_q <= '0;
        end else if (retire) begin
            icnt_q <= icnt_q + 32'd1;
        end
    end

    assign icnt = icnt_q;
`else
    assign icnt = '0;
`endif

endmodule

// File: tb/tb_cpu_seq_ctrl.sv
module tb_cpu_seq_ctrl;

    localparam int unsigned PC_W = 8;
    localparam int unsigned IW   = 16;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            start = 1'b0;
    logic            imem_req;
    logic [PC_W-1:0] imem_addr;
    logic            imem_ack = 1'b0;
    logic [IW-1:0]   ins = '0;
    logic [IW-1:0]   ir;
    logic            dmem_req;
    logic            dmem_ack = 1'b0;
    logic            wr_en;
    logic            m_wr_en;
    logic            select0;
    logic            select1;
    logic [2:0]      alu_op;
    logic            busy;
    logic            halted;
    logic            illegal;
    logic [31:0]     icnt;

    cpu_seq_ctrl #(.PC_W(PC_W), .IW(IW)) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .ins(ins),
        .ir(ir), .dmem_req(dmem_req), .dmem_ack(dmem_ack),
        .wr_en(wr_en), .m_wr_en(m_wr_en), .select0(select0), .select1(select1),
        .alu_op(alu_op), .busy(busy), .halted(halted), .illegal(illegal), .icnt(icnt)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Event kinds: 0 fetch-ack, 1 illegal, 2 regfile write, 3 data-ack, 4 halt entry
    typedef struct {
        int unsigned kind;
        int unsigned cyc;
        logic [31:0] a;
        logic [31:0] b;
    } ev_t;

    ev_t           sb[$];
    int unsigned   idly[$];
    int unsigned   ddly[$];
    logic [IW-1:0] prog [0:255];

    int          checks = 0;
    int          failures = 0;
    bit          mon_en = 0;
    bit          spur = 0;
    bit          iact = 0;
    bit          dact = 0;
    int unsigned iwait = 0;
    int unsigned dwait = 0;
    int unsigned reqc = 0;
    int unsigned mwrc = 0;
    bit          prev_h = 0;
    bit          model_halt = 0;
    int unsigned last_cyc = 0;

    function automatic void chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h", name, got, exp);
        end
    endfunction

    // ---------------- reference model ----------------
    function automatic logic [31:0] alu_word(input logic [2:0] op, input bit s0, input bit s1);
        return {27'd0, op, s0, s1};
    endfunction

    function automatic logic [31:0] exp_icnt(input int unsigned n);
`ifdef CPU_SEQ_ICNT_EN
        return n;
`else
        return 32'd0;
`endif
    endfunction

    function automatic void push_ev(input int unsigned k, input int unsigned c,
                                    input logic [31:0] a, input logic [31:0] b);
        ev_t e;
        e.kind = k; e.cyc = c; e.a = a; e.b = b;
        sb.push_back(e);
        last_cyc = c;
    endfunction

    // Executes the program from pc=0 with start sampled in cycle s and
    // predicts every observable event with its cycle. idm/ddm < 0 means random
    // wait states for instruction/data memory.
    function automatic void model(input int unsigned s, input int idm, input int ddm,
                                  input int unsigned maxn);
        logic [7:0]  pc;
        logic [3:0]  op;
        int unsigned t, f, d, dd, dc, cnt;
        pc = '0; t = s + 1; cnt = 0; model_halt = 0;
        for (int unsigned n = 0; n < maxn; n++) begin
            if (idm < 0) d = $urandom_range(0, 3); else d = idm;
            idly.push_back(d);
            f = t + d;
            push_ev(0, f, {24'd0, pc}, 32'd1);
            op = prog[pc][15:12];
            if (op == 4'd15) begin
                push_ev(4, f + 2, {24'd0, pc}, exp_icnt(cnt));
                model_halt = 1;
                return;
            end
            if (op >= 4'd4) begin
                push_ev(1, f + 1, {24'd0, pc}, 32'd0);
                t = f + 2;
            end else if (op <= 4'd1) begin
                cnt++;
                push_ev(2, f + 2, alu_word(op[2:0], op == 4'd1, 1'b0), 32'd0);
                t = f + 3;
            end else begin
                if (ddm < 0) dd = $urandom_range(0, 3); else dd = ddm;
                ddly.push_back(dd);
                dc = f + 3 + dd;
                push_ev(3, dc, alu_word(op[2:0], 1'b0, 1'b0),
                        ((dd + 1) << 16) | ((op == 4'd2) ? (dd + 1) : 0));
                cnt++;
                if (op == 4'd2) begin
                    t = dc + 1;
                end else begin
                    push_ev(2, dc + 1, alu_word(3'd3, 1'b0, 1'b1), 32'd0);
                    t = dc + 2;
                end
            end
            pc = pc + 8'd1;
        end
    endfunction

    function automatic logic [IW-1:0] rand_ins(input bit allow_halt);
        int unsigned r;
        logic [3:0]  op;
        r = $urandom_range(0, 9);
        if (r < 8) op = 4'(r % 4);
        else if (r == 8) op = 4'($urandom_range(4, 14));
        else op = allow_halt ? 4'd15 : 4'(r % 4);
        return {op, 12'($urandom)};
    endfunction

    // ---------------- memory responders ----------------
    initial forever begin
        @(negedge clk);
        imem_ack = 1'b0;
        if (!rst_n) begin
            iact = 0;
        end else if (imem_req) begin
            if (!iact) begin
                iact = 1;
                iwait = (idly.size() > 0) ? idly.pop_front() : 0;
            end
            if (iwait == 0) begin
                imem_ack = 1'b1;
                ins = prog[imem_addr];
                iact = 0;
            end else begin
                iwait--;
            end
        end else if (spur && $urandom_range(0, 3) == 0) begin
            imem_ack = 1'b1;
            ins = IW'($urandom);
        end
    end

    initial forever begin
        @(negedge clk);
        dmem_ack = 1'b0;
        if (!rst_n) begin
            dact = 0;
        end else if (dmem_req) begin
            if (!dact) begin
                dact = 1;
                dwait = (ddly.size() > 0) ? ddly.pop_front() : 0;
            end
            if (dwait == 0) begin
                dmem_ack = 1'b1;
                dact = 0;
            end else begin
                dwait--;
            end
        end else if (spur && $urandom_range(0, 3) == 0) begin
            dmem_ack = 1'b1;
        end
    end

    // ---------------- monitor ----------------
    function automatic void got_ev(input int unsigned k, input logic [31:0] a, input logic [31:0] b);
        ev_t e;
        checks++;
        if (sb.size() == 0) begin
            failures++;
            $display("FAIL ev_unexpected got kind=%0d cyc=%0d a=%0h b=%0h expected=none", k, cyc, a, b);
            return;
        end
        e = sb.pop_front();
        if (e.kind != k || e.cyc != cyc || e.a !== a || e.b !== b) begin
            failures++;
            $display("FAIL ev got kind=%0d cyc=%0d a=%0h b=%0h expected kind=%0d cyc=%0d a=%0h b=%0h",
                     k, cyc, a, b, e.kind, e.cyc, e.a, e.b);
        end
    endfunction

    initial forever begin
        @(negedge clk);
        #1;
        if (mon_en) begin
            chk("mwr_without_req", {31'd0, m_wr_en & ~dmem_req}, 32'd0);
            if (dmem_req) reqc++;
            if (m_wr_en) mwrc++;
            if (imem_req && imem_ack) got_ev(0, {24'd0, imem_addr}, {31'd0, busy});
            if (illegal) got_ev(1, {24'd0, imem_addr}, 32'd0);
            if (wr_en) got_ev(2, {27'd0, alu_op, select0, select1}, 32'd0);
            if (dmem_req && dmem_ack) begin
                got_ev(3, {27'd0, alu_op, select0, select1}, {reqc[15:0], mwrc[15:0]});
                reqc = 0;
                mwrc = 0;
            end
            if (halted && !prev_h) got_ev(4, {23'd0, busy, imem_addr}, icnt);
            prev_h = halted;
        end
    end

    // ---------------- stimulus ----------------
    task automatic check_idle_outputs(input string tag);
        chk({tag, "_imem_req"}, {31'd0, imem_req}, 32'd0);
        chk({tag, "_dmem_req"}, {31'd0, dmem_req}, 32'd0);
        chk({tag, "_m_wr_en"}, {31'd0, m_wr_en}, 32'd0);
        chk({tag, "_wr_en"}, {31'd0, wr_en}, 32'd0);
        chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
        chk({tag, "_halted"}, {31'd0, halted}, 32'd0);
        chk({tag, "_pc"}, {24'd0, imem_addr}, 32'd0);
        chk({tag, "_ir"}, {16'd0, ir}, 32'd0);
        chk({tag, "_strobes"}, {26'd0, select0, select1, alu_op, illegal}, 32'd0);
        chk({tag, "_icnt"}, icnt, 32'd0);
    endtask

    task automatic do_reset();
        mon_en = 0;
        rst_n = 1'b0;
        #1;
        check_idle_outputs("rst");
        sb.delete();
        idly.delete();
        ddly.delete();
        iact = 0;
        dact = 0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        reqc = 0;
        mwrc = 0;
        prev_h = 0;
        mon_en = 1;
    endtask

    task automatic drain();
        for (int i = 0; i < 60; i++) begin
            #2;
            if (sb.size() == 0) return;
            @(negedge clk);
        end
        checks++;
        failures++;
        $display("FAIL drain_timeout pending=%0d expected=0", sb.size());
        sb.delete();
    endtask

    task automatic run(input int idm, input int ddm, input int unsigned maxn, input bit noise);
        int unsigned s;
        @(negedge clk);
        s = cyc;
        model(s, idm, ddm, maxn);
        start = 1'b1;
        @(negedge clk);
        while (cyc < last_cyc) begin
            start = noise && ($urandom_range(0, 2) == 0);
            @(negedge clk);
        end
        start = 1'b0;
        drain();
        if (!model_halt) do_reset();
    endtask

    initial begin
        for (int i = 0; i < 256; i++) prog[i] = '0;
        #3;
        check_idle_outputs("init");
        @(negedge clk);
        rst_n = 1'b1;
        mon_en = 1;

        // add then halt, zero-wait
        prog[0] = 16'h0123;
        prog[1] = 16'hF000;
        run(0, 0, 10, 0);

        // iadd, st, ld, halt with two data wait states
        prog[0] = 16'h1456;
        prog[1] = 16'h2789;
        prog[2] = 16'h3ABC;
        prog[3] = 16'hF000;
        run(0, 2, 10, 0);

        // undefined opcode followed by add, halt
        prog[0] = 16'h7000;
        prog[1] = 16'h0111;
        prog[2] = 16'hF000;
        run(0, 0, 10, 0);

        // stray start pulses and acks while a program runs
        spur = 1;
        prog[0] = 16'h0001;
        prog[1] = 16'h2002;
        prog[2] = 16'h1003;
        prog[3] = 16'h3004;
        prog[4] = 16'hF000;
        run(-1, -1, 10, 1);
        spur = 0;

        // asynchronous reset while a store is waiting on dmem_ack
        prog[0] = 16'h2000;
        prog[1] = 16'hF000;
        @(negedge clk);
        model(cyc, 0, 8, 1);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 20 && !dmem_req; i++) @(negedge clk);
        #2;
        chk("mid_mem_dmem_req", {31'd0, dmem_req}, 32'd1);
        chk("mid_mem_m_wr_en", {31'd0, m_wr_en}, 32'd1);
        do_reset();
        prog[0] = 16'h0000;
        prog[1] = 16'hF000;
        run(0, 0, 10, 0);

        // pc wrap: no halt anywhere, run past address 255
        spur = 1;
        for (int i = 0; i < 256; i++) prog[i] = rand_ins(0);
        run(-1, 0, 300, 1);

        // random programs with halts
        for (int k = 0; k < 8; k++) begin
            for (int i = 0; i < 256; i++) prog[i] = rand_ins(1);
            run(-1, -1, 40, 1);
        end
        spur = 0;

        repeat (3) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
